divider: RTL
============

# divider

Sequential 8-bit unsigned restoring divider for the Lab 5 datapath; the inverse of the shift-add multiplier. It uses the same board interface: switches, ClearA_LoadB, Execute, and A/B register values on the hex displays. The dividend is loaded into B and the divisor is captured from the switches at Execute. After 16 cycles, B holds the quotient and A holds the remainder.

## Interface
- WIDTH, 8, operand/result width (only 8 is verified)
- Clk  in  1  system clock; all state changes on rising edge
- Reset_h  in  1  synchronous, active-high reset
- ClearA_LoadB_h  in  1  level; in IDLE: A←0, Q(B)←sw
- Execute_h  in  1  level; in IDLE: M←sw, start division
- sw  in  8  switch operand (dividend at load, divisor at execute)
- Aval  out  8  A[7:0], remainder when Done
- Bval  out  8  Q register, quotient when Done
- Done  out  1  high in DONE state
- DivZero  out  1  latched high if captured divisor was 0
- AhexU, AhexL, BhexU, BhexL  out  7 each  active-low 7-segment of Aval/Bval nibbles

## Operation
- Registers: A 9 bits (restore headroom; shifted partial remainder reaches 2·M−1 ≤ 509), Q 8 bits, M 8 bits, count 3 bits, state.
- States: IDLE, SHIFT, SUB, DONE.
- IDLE:
  - Execute_h=1 → M←sw, count←0, DivZero←(sw==0), go to SHIFT.
  - Else if ClearA_LoadB_h=1 → A←0, Q←sw, DivZero←0.
  - Execute has priority when both are high.
- SHIFT: {A,Q}←{A,Q}<<1 (A[8:1]←A[7:0], A[0]←Q[7], Q[0]←0) → SUB.
- SUB: diff = {1'b0,A} − {2'b0,M} (10-bit).
  - diff[9]==0 → A←diff[8:0], Q[0]←1.
  - Else A unchanged, Q[0]←0.
  - If count==7 → DONE; else count++ → SHIFT.
- DONE: Done=1; results held; holds until Execute_h=0 → IDLE. ClearA_LoadB_h is ignored outside IDLE.
- Divide by zero: no special path. The algorithm yields Q=0xFF and A=dividend; DivZero=1.
- A is not cleared at Execute. Correct results require a ClearA_LoadB before each division; back-to-back Execute reuses the prior remainder/quotient (matches multiplier usage).
- Hex outputs are combinational from Aval/Bval.

## Timing
- Reset (synchronous, takes effect at the next edge with Reset_h=1): state=IDLE, A=0, Q=0, M=0, count=0, Done=0, DivZero=0. Aval/Bval=0x00, all hex show "0" (7'b1000000).
- Reset asserted in any state, including mid-division, aborts the division at that edge with the same values.
- Latency: with Execute_h sampled high in IDLE at edge 0, SHIFT/SUB occupy edges 1–16. Done=1 and results are valid after edge 16, for the cycle following it.
- Execute held high for many cycles runs exactly one division; re-arm requires Execute_h low for at least one cycle (DONE→IDLE).
- Aval/Bval show intermediate values during SHIFT/SUB; they are valid only when Done=1.

## Structure
- Package divider_pkg: state enum (IDLE, SHIFT, SUB, DONE), WIDTH localparam, count width.
- Sub-module hex_driver: 4-bit → 7-bit active-low segment decode, instantiated 4×.
- FSM and datapath stay in divider; a separate control module is not required.

## Test plan
- Reset, ClearA_LoadB with sw=0xC5, Execute with sw=0x07 → after 17 cycles, Bval=0x1C, Aval=0x01, Done=1, DivZero=0.
- Load 0xFF, divisor 0x80 → Bval=0x01, Aval=0x7F. Exercises the 9-bit A path.
- Load 0x07, divisor 0xC5 → Bval=0x00, Aval=0x07. Load 0xFF, divisor 0x01 → Bval=0xFF, Aval=0x00.
- Load 0x80, divisor 0x00 → Bval=0xFF, Aval=0x80, DivZero=1. A following ClearA_LoadB clears DivZero.
- Hold Execute_h high for 40 cycles → single result, Done stays 1, and a ClearA_LoadB pulse in DONE changes nothing. Release Execute_h → IDLE next cycle.
- Assert Reset_h at cycle 8 of a division → next edge: A=Q=0, Done=0, IDLE. A subsequent full load/execute gives the correct result.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and sizing for the restoring divider.
package divider_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/hex_driver.sv
// Nibble to active-low 7-segment decode (segment order gfedcba).
module hex_driver (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: B (Q) holds the quotient and A the
// remainder after eight SHIFT/SUB pairs.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = divider_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_h,
  input  logic             ClearA_LoadB_h,
  input  logic             Execute_h,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Done,
  output logic             DivZero,
  output logic [6:0]       AhexU,
  output logic [6:0]       AhexL,
  output logic [6:0]       BhexU,
  output logic [6:0]       BhexL
);

  state_e           state_q;
  logic [WIDTH:0]   A_q;
  logic [WIDTH-1:0] Q_q;
  logic [WIDTH-1:0] M_q;
  logic [CNT_W-1:0] count_q;
  logic             Done_q;
  logic             DivZero_q;
  logic [WIDTH+1:0] diff_d;

  // Extra sign bit: a borrow means the trial subtraction must be discarded.
  always_comb begin
    diff_d = {1'b0, A_q} - {2'b00, M_q};
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q   <= IDLE;
      A_q       <= '0;
      Q_q       <= '0;
      M_q       <= '0;
      count_q   <= '0;
      Done_q    <= 1'b0;
      DivZero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Execute_h) begin
            M_q       <= sw;
            count_q   <= '0;
            DivZero_q <= (sw == '0);
            state_q   <= SHIFT;
          end else if (ClearA_LoadB_h) begin
            A_q       <= '0;
            Q_q       <= sw;
            DivZero_q <= 1'b0;
          end
        end
        SHIFT: begin
          A_q     <= {A_q[WIDTH-1:0], Q_q[WIDTH-1]};
          Q_q     <= {Q_q[WIDTH-2:0], 1'b0};
          state_q <= SUB;
        end
        SUB: begin
          if (!diff_d[WIDTH+1]) begin
            A_q    <= diff_d[WIDTH:0];
            Q_q[0] <= 1'b1;
          end
          if (count_q == CNT_W'(WIDTH - 1)) begin
            Done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
            state_q <= SHIFT;
          end
        end
        DONE: begin
          if (!Execute_h) begin
            Done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Aval    = A_q[WIDTH-1:0];
  assign Bval    = Q_q;
  assign Done    = Done_q;
  assign DivZero = DivZero_q;

  hex_driver u_hex_au (.hex_i(Aval[7:4]), .seg_o(AhexU));
  hex_driver u_hex_al (.hex_i(Aval[3:0]), .seg_o(AhexL));
  hex_driver u_hex_bu (.hex_i(Bval[7:4]), .seg_o(BhexU));
  hex_driver u_hex_bl (.hex_i(Bval[3:0]), .seg_o(BhexL));

endmodule
